// File: rtl/alu_rs_issue.sv
// ALU reservation station. It is a collapsing issue queue with the oldest entry at index 0.
// Entries wake up by snooping the CDB, and the oldest ready entry issues on a valid/ready handshake.
module alu_rs_issue #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned PAYLOAD_W   = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             squash,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic                             disp_rs1_rdy,
    input  logic [TAG_W-1:0]                 disp_rs1_tag,
    input  logic [XLEN-1:0]                  disp_rs1_val,
    input  logic                             disp_rs2_rdy,
    input  logic [TAG_W-1:0]                 disp_rs2_tag,
    input  logic [XLEN-1:0]                  disp_rs2_val,
    input  logic [TAG_W-1:0]                 disp_dest_tag,
    input  logic [PAYLOAD_W-1:0]             disp_payload,
    input  logic                             cdb_valid,
    input  logic [TAG_W-1:0]                 cdb_tag,
    input  logic [XLEN-1:0]                  cdb_value,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [XLEN-1:0]                  iss_rs1_val,
    output logic [XLEN-1:0]                  iss_rs2_val,
    output logic [TAG_W-1:0]                 iss_dest_tag,
    output logic [PAYLOAD_W-1:0]             iss_payload,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic                 vld;
        logic                 rs1_rdy;
        logic [TAG_W-1:0]     rs1_tag;
        logic [XLEN-1:0]      rs1_val;
        logic                 rs2_rdy;
        logic [TAG_W-1:0]     rs2_tag;
        logic [XLEN-1:0]      rs2_val;
        logic [TAG_W-1:0]     dest_tag;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t             ent_q [NUM_ENTRIES];
    entry_t             ent_d [NUM_ENTRIES];
    // The extra top slot is always empty, so the shift-down can read index i+1 without a guard.
    entry_t             woke  [NUM_ENTRIES+1];
    entry_t             new_ent;
    logic [CNT_W-1:0]   count_q, count_d, wr_pos;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               disp_fire, iss_fire;

    // Apply this cycle's CDB wakeup to every waiting operand.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woke[i] = ent_q[i];
            if (ent_q[i].vld && !ent_q[i].rs1_rdy && cdb_valid && cdb_tag == ent_q[i].rs1_tag) begin
                woke[i].rs1_rdy = 1'b1;
                woke[i].rs1_val = cdb_value;
            end
            if (ent_q[i].vld && !ent_q[i].rs2_rdy && cdb_valid && cdb_tag == ent_q[i].rs2_tag) begin
                woke[i].rs2_rdy = 1'b1;
                woke[i].rs2_val = cdb_value;
            end
        end
        woke[NUM_ENTRIES] = '0;
    end

    // Oldest-first select over registered state only, so there is no CDB-to-issue bypass.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].vld && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Handshake and output datapath. The data outputs read zero when nothing is selected or in reset.
    always_comb begin
        disp_ready   = (count_q < CNT_W'(NUM_ENTRIES));
        count        = count_q;
        iss_valid    = sel_found && !squash && !reset;
        disp_fire    = disp_valid && disp_ready && !squash;
        iss_fire     = iss_valid && iss_ready;
        iss_rs1_val  = '0;
        iss_rs2_val  = '0;
        iss_dest_tag = '0;
        iss_payload  = '0;
        if (sel_found && !reset) begin
            iss_rs1_val  = ent_q[sel_idx].rs1_val;
            iss_rs2_val  = ent_q[sel_idx].rs2_val;
            iss_dest_tag = ent_q[sel_idx].dest_tag;
            iss_payload  = ent_q[sel_idx].payload;
        end
    end

    // Build the incoming entry and apply the dispatch-time CDB bypass.
    always_comb begin
        new_ent          = '0;
        new_ent.vld      = 1'b1;
        new_ent.rs1_rdy  = disp_rs1_rdy;
        new_ent.rs1_tag  = disp_rs1_tag;
        new_ent.rs1_val  = disp_rs1_val;
        new_ent.rs2_rdy  = disp_rs2_rdy;
        new_ent.rs2_tag  = disp_rs2_tag;
        new_ent.rs2_val  = disp_rs2_val;
        new_ent.dest_tag = disp_dest_tag;
        new_ent.payload  = disp_payload;
        if (!disp_rs1_rdy && cdb_valid && cdb_tag == disp_rs1_tag) begin
            new_ent.rs1_rdy = 1'b1;
            new_ent.rs1_val = cdb_value;
        end
        if (!disp_rs2_rdy && cdb_valid && cdb_tag == disp_rs2_tag) begin
            new_ent.rs2_rdy = 1'b1;
            new_ent.rs2_val = cdb_value;
        end
    end

    // Next state: collapse over the issued slot, then append the dispatch at the new tail.
    always_comb begin
        count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
        wr_pos  = count_q - CNT_W'(iss_fire);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (iss_fire && (IDX_W'(i) >= sel_idx)) begin
                ent_d[i] = woke[i+1];
            end else begin
                ent_d[i] = woke[i];
            end
            if (disp_fire && (CNT_W'(i) == wr_pos)) begin
                ent_d[i] = new_ent;
            end
        end
        if (squash) begin
            count_d = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    // State registers with a synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
